ram_nr1w_wr_arbiter: RTL and testbench
======================================

Name: ram_nr1w_wr_arbiter

Overview:
- Shares the single write port of an N-read/1-write LUTRAM between REQ_NB independent writers.
- Uses round-robin arbitration and valid/ready handshakes per requester.
- Drives the RAM write port from registers.
- Optionally sequences an initialisation sweep that writes INIT_VAL to every word after reset or on a clear request, because the LUTRAM contents cannot be reset asynchronously.

Parameters:
WIDTH, 32, RAM data width
DEPTH, 512, RAM depth in words; need not be a power of 2
REQ_NB, 4, number of write requesters (>=1)
INIT_VAL, '0, WIDTH-bit value written by the init sweep
ADD_W, $clog2(DEPTH), localparam, address width

Ports:
clk  in  1  clock
s_rst_n  in  1  asynchronous active-low reset
clr  in  1  pulse: request a re-initialisation sweep
req_vld  in  [REQ_NB]  per-requester write valid
req_rdy  out  [REQ_NB]  per-requester write accepted (grant)
req_add  in  [REQ_NB] x ADD_W  per-requester write address
req_data  in  [REQ_NB] x WIDTH  per-requester write data
ram_wr_en  out  1  RAM write enable
ram_wr_add  out  ADD_W  RAM write address
ram_wr_data  out  WIDTH  RAM write data
init_done  out  1  high once the RAM content is valid
busy  out  1  high while an init sweep runs

Behaviour:
- Reset values:
  - ram_wr_en=0, ram_wr_add=0, ram_wr_data=0, req_rdy=0.
  - busy=1 and init_done=0 with the macro; busy=0 and init_done=1 without it.
  - Round-robin pointer=REQ_NB-1, so requester 0 has first priority.
- Asserting s_rst_n low at any time, including mid-sweep, returns all state to reset values immediately. A new sweep restarts from address 0 after release.
- FSM states INIT and ARB. Reset enters INIT (macro on) or ARB (macro off).
- INIT:
  - One write per cycle: ram_wr_en=1, ram_wr_add=sweep counter, ram_wr_data=INIT_VAL.
  - Counter runs 0..DEPTH-1. Exactly DEPTH writes, no wrap beyond DEPTH-1.
  - req_rdy all 0.
  - After the DEPTH-1 write, go to ARB. busy falls and init_done rises in the same cycle as the first ARB cycle.
  - clr during INIT is ignored.
- ARB:
  - Grant search starts at pointer+1 mod REQ_NB; the first index with req_vld=1 wins.
  - req_rdy[winner]=1 combinationally in the same cycle; all other req_rdy are 0.
  - Handshake = req_vld[i] & req_rdy[i]. The requester must hold vld, add and data stable until rdy.
  - On handshake, the pointer updates to the winner. The next cycle has ram_wr_en=1 with the captured add/data.
  - Write latency: 1 cycle from handshake to ram_wr_en. Throughput: 1 write per cycle.
  - No handshake -> ram_wr_en=0 the next cycle. ram_wr_add/ram_wr_data hold their last value.
- clr in ARB (macro on):
  - No grant is issued in that cycle.
  - The next state is INIT with the counter reset to 0, init_done=0 and busy=1.
  - A write handshaken in the previous cycle still completes, and does so before the sweep starts.
- Writes to the same address from different requesters on consecutive grants are issued in grant order. The later grant overwrites the earlier one.
- REQ_NB=1: requester 0 is always granted when valid.

Optional Feature:
RAM_NR1W_WR_ARB_INIT_EN
- Defined: INIT state, sweep counter, clr handling and busy/init_done sequencing are present as described above.
- Undefined: no INIT state and no sweep counter. FSM is permanently ARB. init_done is constant 1, busy is constant 0, and clr is ignored. Arbitration is available on the first cycle after reset release.

Test Plan:
- Reset, macro on, DEPTH=5 -> ram_wr_en=1 for 5 consecutive cycles with addresses 0,1,2,3,4 and data INIT_VAL; init_done rises on cycle 6; req_rdy=0 throughout the sweep.
- All 4 req_vld held high with add=i and data=0x10+i -> grants in order 0,1,2,3,0; ram_wr_add sequence 0,1,2,3,0 one cycle after each grant, back-to-back.
- Only req 2 valid, then only req 1 -> req 2 granted; next grant to req 1 as the only requester; no idle cycles inserted.
- clr pulsed in ARB while req 0 is valid -> req 0 not granted that cycle; sweep restarts at address 0; req 0 granted in the first cycle after init_done rises.
- s_rst_n low at sweep address 3 -> outputs take reset values immediately; after release the sweep restarts at address 0.
- Macro off -> init_done=1 out of reset; req 3 valid with add=7 and data=0xABCD -> ram_wr_en=1, add=7, data=0xABCD one cycle after the handshake.

Source files
------------

// File: rtl/ram_nr1w_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of an N-read/1-write LUTRAM.
// Define RAM_NR1W_WR_ARB_INIT_EN to add the INIT_VAL sweep after reset or clr.
module ram_nr1w_wr_arbiter #(
    parameter int                WIDTH    = 32,
    parameter int                DEPTH    = 512,
    parameter int                REQ_NB   = 4,
    parameter logic [WIDTH-1:0]  INIT_VAL = '0,
    localparam int               ADD_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                              clk,
    input  logic                              s_rst_n,
    input  logic                              clr,
    input  logic [REQ_NB-1:0]                 req_vld,
    output logic [REQ_NB-1:0]                 req_rdy,
    input  logic [REQ_NB-1:0][ADD_W-1:0]      req_add,
    input  logic [REQ_NB-1:0][WIDTH-1:0]      req_data,
    output logic                              ram_wr_en,
    output logic [ADD_W-1:0]                  ram_wr_add,
    output logic [WIDTH-1:0]                  ram_wr_data,
    output logic                              init_done,
    output logic                              busy
);

    localparam int PTR_W = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;

    typedef struct packed {
        logic [ADD_W-1:0] add;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             arb_en;
    logic             hs;
    logic             sweep_wr;
    logic [ADD_W-1:0] sweep_add;
    wr_req_t          wr_q;

`ifdef RAM_NR1W_WR_ARB_INIT_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ADD_W-1:0] sweep_cnt;
    logic             sweep_last;

    assign sweep_last = (sweep_cnt == ADD_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) state <= ST_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT) begin
            if (sweep_last) state_nxt = ST_ARB;
        end else begin
            if (clr) state_nxt = ST_INIT;
        end
    end

    // clr wins over arbitration so no grant is lost across the restart
    always_comb begin
        busy      = (state == ST_INIT);
        init_done = (state == ST_ARB);
        arb_en    = (state == ST_ARB) && !clr;
        sweep_wr  = (state == ST_INIT);
        sweep_add = sweep_cnt;
    end

    // Counter parks at 0 outside INIT, so any entry into INIT starts at address 0
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n)                          sweep_cnt <= '0;
        else if (state == ST_INIT && !sweep_last) sweep_cnt <= sweep_cnt + ADD_W'(1);
        else                                   sweep_cnt <= '0;
    end
`else
    logic unused_clr;

    assign unused_clr = clr;
    assign busy       = 1'b0;
    assign init_done  = 1'b1;
    assign arb_en     = 1'b1;
    assign sweep_wr   = 1'b0;
    assign sweep_add  = '0;
`endif

    // Scan from farthest to nearest so the nearest valid index after rr_ptr wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = REQ_NB; k >= 1; k--) begin
            cand = PTR_W'((int'(rr_ptr) + k) % REQ_NB);
            if (req_vld[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign hs = arb_en && gnt_vld;

    always_comb begin
        req_rdy = '0;
        if (hs) req_rdy[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ram_wr_en <= 1'b0;
            wr_q      <= '0;
            rr_ptr    <= PTR_W'(REQ_NB - 1);
        end else if (sweep_wr) begin
            ram_wr_en <= 1'b1;
            wr_q.add  <= sweep_add;
            wr_q.data <= INIT_VAL;
        end else begin
            ram_wr_en <= hs;
            if (hs) begin
                wr_q.add  <= req_add[gnt_idx];
                wr_q.data <= req_data[gnt_idx];
                rr_ptr    <= gnt_idx;
            end
        end
    end

    assign ram_wr_add  = wr_q.add;
    assign ram_wr_data = wr_q.data;

endmodule

// File: tb/tb_ram_nr1w_wr_arbiter.sv
// Bench for ram_nr1w_wr_arbiter: directed scenarios plus random traffic against a grant/write model.
module tb_ram_nr1w_wr_arbiter;

    localparam int               WIDTH    = 16;
    localparam int               DEPTH    = 5;
    localparam int               REQ_NB   = 4;
    localparam int               ADD_W    = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] INIT_VAL = 16'h5A5A;
`ifdef RAM_NR1W_WR_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         s_rst_n = 1'b0;
    logic                         clr = 1'b0;
    logic [REQ_NB-1:0]            req_vld = '0;
    logic [REQ_NB-1:0]            req_rdy;
    logic [REQ_NB-1:0][ADD_W-1:0] req_add = '0;
    logic [REQ_NB-1:0][WIDTH-1:0] req_data = '0;
    logic                         ram_wr_en;
    logic [ADD_W-1:0]             ram_wr_add;
    logic [WIDTH-1:0]             ram_wr_data;
    logic                         init_done;
    logic                         busy;

    int checks = 0;
    int failures = 0;

    // Reference model: last winner, sweep progress and expected write-port registers
    int               m_ptr;
    int               m_cnt;
    bit               m_init;
    logic             m_en;
    logic [ADD_W-1:0] m_add;
    logic [WIDTH-1:0] m_data;

    ram_nr1w_wr_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .REQ_NB(REQ_NB), .INIT_VAL(INIT_VAL)
    ) dut (
        .clk(clk), .s_rst_n(s_rst_n), .clr(clr),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_add(req_add), .req_data(req_data),
        .ram_wr_en(ram_wr_en), .ram_wr_add(ram_wr_add), .ram_wr_data(ram_wr_data),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        if (!s_rst_n || m_init || (INIT_EN && clr)) return -1;
        for (int k = 1; k <= REQ_NB; k++) begin
            int i = (m_ptr + k) % REQ_NB;
            if (req_vld[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [REQ_NB-1:0] model_rdy();
        int g = model_grant();
        model_rdy = '0;
        if (g >= 0) model_rdy[g] = 1'b1;
    endfunction

    // Advance one clock; the model consumes the inputs present just before the edge
    task automatic tick();
        int g = model_grant();
        bit c = clr;
        @(posedge clk);
        if (m_init) begin
            m_en = 1'b1; m_add = ADD_W'(m_cnt); m_data = INIT_VAL;
            if (m_cnt == DEPTH - 1) m_init = 1'b0;
            else m_cnt++;
        end else if (INIT_EN && c) begin
            m_en = 1'b0; m_init = 1'b1; m_cnt = 0;
        end else if (g >= 0) begin
            m_en = 1'b1; m_add = req_add[g]; m_data = req_data[g]; m_ptr = g;
        end else begin
            m_en = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        req_vld = '0;
        clr     = 1'b0;
        s_rst_n = 1'b0;
        #1;
        checks++; if (ram_wr_en !== 1'b0 || ram_wr_add !== '0 || ram_wr_data !== '0) begin
            failures++; $display("FAIL reset_port: got en=%b add=%0d data=%h want 0/0/0", ram_wr_en, ram_wr_add, ram_wr_data); end
        checks++; if (req_rdy !== '0) begin
            failures++; $display("FAIL reset_rdy: got %b want 0", req_rdy); end
        checks++; if (busy !== INIT_EN || init_done !== !INIT_EN) begin
            failures++; $display("FAIL reset_status: got busy=%b done=%b want %b/%b", busy, init_done, INIT_EN, !INIT_EN); end
        repeat (2) @(negedge clk);
        s_rst_n = 1'b1;
        m_ptr = REQ_NB - 1; m_init = INIT_EN; m_cnt = 0;
        m_en = 1'b0; m_add = '0; m_data = '0;
    endtask

    task automatic test_init_sweep();
        int n_wr = 0;
        req_vld = '1;
        for (int n = 0; n < DEPTH + 2 && m_init; n++) begin
            #1;
            checks++; if (req_rdy !== '0 || busy !== 1'b1 || init_done !== 1'b0) begin
                failures++; $display("FAIL sweep_status: got rdy=%b busy=%b done=%b want 0/1/0", req_rdy, busy, init_done); end
            checks++; if (ram_wr_en !== m_en || ram_wr_add !== m_add || ram_wr_data !== m_data) begin
                failures++; $display("FAIL sweep_port: got en=%b add=%0d data=%h want %b/%0d/%h", ram_wr_en, ram_wr_add, ram_wr_data, m_en, m_add, m_data); end
            if (ram_wr_en === 1'b1) n_wr++;
            tick();
        end
        #1;
        checks++; if (init_done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL sweep_done: got done=%b busy=%b want 1/0", init_done, busy); end
        checks++; if (ram_wr_en !== 1'b1 || ram_wr_add !== ADD_W'(DEPTH - 1) || ram_wr_data !== INIT_VAL) begin
            failures++; $display("FAIL sweep_last: got en=%b add=%0d data=%h want 1/%0d/%h", ram_wr_en, ram_wr_add, ram_wr_data, DEPTH - 1, INIT_VAL); end
        if (ram_wr_en === 1'b1) n_wr++;
        checks++; if (n_wr != DEPTH) begin
            failures++; $display("FAIL sweep_count: got %0d writes want %0d", n_wr, DEPTH); end
        req_vld = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < REQ_NB; i++) begin
            req_add[i]  = ADD_W'(i);
            req_data[i] = WIDTH'(16'h10 + i);
        end
        req_vld = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_rdy !== (REQ_NB'(1) << order[k])) begin
                failures++; $display("FAIL rr_grant%0d: got %b want req %0d", k, req_rdy, order[k]); end
            if (k > 0) begin
                checks++; if (ram_wr_en !== 1'b1 || ram_wr_add !== ADD_W'(order[k-1]) || ram_wr_data !== WIDTH'(16'h10 + order[k-1])) begin
                    failures++; $display("FAIL rr_write%0d: got en=%b add=%0d data=%h want 1/%0d/%h", k, ram_wr_en, ram_wr_add, ram_wr_data, order[k-1], 16'h10 + order[k-1]); end
            end
            tick();
        end
        req_vld = '0;
        #1;
        checks++; if (ram_wr_en !== 1'b1 || ram_wr_add !== '0 || ram_wr_data !== 16'h10) begin
            failures++; $display("FAIL rr_tail: got en=%b add=%0d data=%h want 1/0/10", ram_wr_en, ram_wr_add, ram_wr_data); end
        tick();
    endtask

    task automatic test_single_switch();
        logic [ADD_W-1:0] a2 = ADD_W'($urandom_range(0, DEPTH - 1));
        logic [ADD_W-1:0] a1 = ADD_W'($urandom_range(0, DEPTH - 1));
        logic [WIDTH-1:0] d2 = WIDTH'($urandom);
        logic [WIDTH-1:0] d1 = WIDTH'($urandom);
        req_vld = 4'b0100; req_add[2] = a2; req_data[2] = d2;
        #1;
        checks++; if (req_rdy !== 4'b0100) begin
            failures++; $display("FAIL sw_grant2: got %b want 0100", req_rdy); end
        tick();
        req_vld = 4'b0010; req_add[1] = a1; req_data[1] = d1;
        #1;
        checks++; if (req_rdy !== 4'b0010) begin
            failures++; $display("FAIL sw_grant1: got %b want 0010", req_rdy); end
        checks++; if (ram_wr_en !== 1'b1 || ram_wr_add !== a2 || ram_wr_data !== d2) begin
            failures++; $display("FAIL sw_write2: got en=%b add=%0d data=%h want 1/%0d/%h", ram_wr_en, ram_wr_add, ram_wr_data, a2, d2); end
        tick();
        req_vld = '0;
        #1;
        checks++; if (ram_wr_en !== 1'b1 || ram_wr_add !== a1 || ram_wr_data !== d1) begin
            failures++; $display("FAIL sw_write1: got en=%b add=%0d data=%h want 1/%0d/%h", ram_wr_en, ram_wr_add, ram_wr_data, a1, d1); end
        tick();
        #1;
        checks++; if (ram_wr_en !== 1'b0 || ram_wr_add !== a1 || ram_wr_data !== d1) begin
            failures++; $display("FAIL sw_idle_hold: got en=%b add=%0d data=%h want 0/%0d/%h", ram_wr_en, ram_wr_add, ram_wr_data, a1, d1); end
    endtask

    task automatic test_single_write();
        req_vld = 4'b1000; req_add[3] = 3'd7; req_data[3] = 16'hABCD;
        #1;
        checks++; if (init_done !== 1'b1 || req_rdy !== 4'b1000) begin
            failures++; $display("FAIL sw3_grant: got done=%b rdy=%b want 1/1000", init_done, req_rdy); end
        tick();
        req_vld = '0;
        #1;
        checks++; if (ram_wr_en !== 1'b1 || ram_wr_add !== 3'd7 || ram_wr_data !== 16'hABCD) begin
            failures++; $display("FAIL sw3_write: got en=%b add=%0d data=%h want 1/7/abcd", ram_wr_en, ram_wr_add, ram_wr_data); end
        tick();
    endtask

`ifdef RAM_NR1W_WR_ARB_INIT_EN
    task automatic test_clr();
        logic [ADD_W-1:0] a0 = ADD_W'($urandom_range(0, DEPTH - 1));
        logic [WIDTH-1:0] d0 = WIDTH'($urandom);
        req_vld = 4'b0010; req_add[1] = 3'd2; req_data[1] = 16'h1111;
        #1;
        checks++; if (req_rdy !== 4'b0010) begin
            failures++; $display("FAIL clr_pre_grant: got %b want 0010", req_rdy); end
        tick();
        req_vld = 4'b0001; req_add[0] = a0; req_data[0] = d0; clr = 1'b1;
        #1;
        checks++; if (req_rdy !== '0) begin
            failures++; $display("FAIL clr_no_grant: got %b want 0", req_rdy); end
        checks++; if (ram_wr_en !== 1'b1 || ram_wr_add !== 3'd2 || ram_wr_data !== 16'h1111) begin
            failures++; $display("FAIL clr_prior_write: got en=%b add=%0d data=%h want 1/2/1111", ram_wr_en, ram_wr_add, ram_wr_data); end
        tick();
        clr = 1'b0;
        for (int n = 0; n < DEPTH + 2 && m_init; n++) begin
            #1;
            checks++; if (req_rdy !== '0 || busy !== 1'b1 || init_done !== 1'b0) begin
                failures++; $display("FAIL clr_sweep_status: got rdy=%b busy=%b done=%b want 0/1/0", req_rdy, busy, init_done); end
            checks++; if (ram_wr_en !== m_en || ram_wr_add !== m_add || ram_wr_data !== m_data) begin
                failures++; $display("FAIL clr_sweep_port: got en=%b add=%0d data=%h want %b/%0d/%h", ram_wr_en, ram_wr_add, ram_wr_data, m_en, m_add, m_data); end
            tick();
        end
        #1;
        checks++; if (init_done !== 1'b1 || req_rdy !== 4'b0001) begin
            failures++; $display("FAIL clr_regrant: got done=%b rdy=%b want 1/0001", init_done, req_rdy); end
        tick();
        req_vld = '0;
        #1;
        checks++; if (ram_wr_en !== 1'b1 || ram_wr_add !== a0 || ram_wr_data !== d0) begin
            failures++; $display("FAIL clr_req0_write: got en=%b add=%0d data=%h want 1/%0d/%h", ram_wr_en, ram_wr_add, ram_wr_data, a0, d0); end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        test_reset();
        for (int n = 0; n < 4; n++) tick();
        #1;
        checks++; if (ram_wr_en !== 1'b1 || ram_wr_add !== 3'd3) begin
            failures++; $display("FAIL mid_sweep_pos: got en=%b add=%0d want 1/3", ram_wr_en, ram_wr_add); end
        test_reset();
        test_init_sweep();
    endtask
`endif

    task automatic test_random();
        bit pend[REQ_NB];
        for (int i = 0; i < REQ_NB; i++) pend[i] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int g;
            for (int i = 0; i < REQ_NB; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]     = 1'b1;
                    req_add[i]  = ADD_W'($urandom_range(0, DEPTH - 1));
                    req_data[i] = WIDTH'($urandom);
                end
                req_vld[i] = pend[i];
            end
            clr = ($urandom_range(0, 39) == 0);
            #1;
            checks++; if (req_rdy !== model_rdy()) begin
                failures++; $display("FAIL rnd_rdy@%0d: got %b want %b", n, req_rdy, model_rdy()); end
            checks++; if (ram_wr_en !== m_en || ram_wr_add !== m_add || ram_wr_data !== m_data) begin
                failures++; $display("FAIL rnd_port@%0d: got en=%b add=%0d data=%h want %b/%0d/%h", n, ram_wr_en, ram_wr_add, ram_wr_data, m_en, m_add, m_data); end
            checks++; if (busy !== m_init || init_done !== !m_init) begin
                failures++; $display("FAIL rnd_status@%0d: got busy=%b done=%b want %b/%b", n, busy, init_done, m_init, !m_init); end
            g = model_grant();
            if (g >= 0) pend[g] = 1'b0;
            tick();
        end
        req_vld = '0;
        clr     = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef RAM_NR1W_WR_ARB_INIT_EN
        test_init_sweep();
`endif
        test_round_robin();
        test_single_switch();
        test_single_write();
`ifdef RAM_NR1W_WR_ARB_INIT_EN
        test_clr();
        test_reset_mid_sweep();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
